// File: rtl/cla_adder_reg.sv
// Registered NBIT-wide two-level carry-lookahead adder: 4-bit lookahead groups
// feeding a group-level lookahead unit, with sum/carry captured on valid input.

module cla_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [3:0] c,
  output logic       gg,
  output logic       pg
);
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg   = &p;
endmodule

module cla_adder_reg #(
  parameter int NBIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            cin,
  input  logic            in_valid,
  output logic [NBIT-1:0] s,
  output logic            cout,
  output logic            out_valid
);
  localparam int NGRP = (NBIT + 3) / 4;
  localparam int NPAD = NGRP * 4;

  logic [NPAD-1:0] g_w, p_w, c_w;
  logic [NGRP-1:0] gg_w, pg_w;
  logic [NGRP:0]   gc_w;
  logic [NBIT-1:0] sum_w;
  logic            cout_w;

  logic [NBIT-1:0] s_q, s_d;
  logic            cout_q, cout_d;
  logic            vld_q, vld_d;

  // Padding bits of a partial top group are g=0, p=0.
  always_comb begin
    g_w = '0;
    p_w = '0;
    g_w[NBIT-1:0] = a & b;
    p_w[NBIT-1:0] = a ^ b;
  end

  // Second-level lookahead, flattened sum-of-products per group boundary.
  always_comb begin
    logic acc, term;
    gc_w    = '0;
    gc_w[0] = cin;
    for (int k = 1; k <= NGRP; k++) begin
      acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        term = gg_w[j];
        for (int m = j + 1; m < k; m++) term = term & pg_w[m];
        acc = acc | term;
      end
      term = cin;
      for (int m = 0; m < k; m++) term = term & pg_w[m];
      gc_w[k] = acc | term;
    end
  end

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    cla_group4 u_grp (
      .g  (g_w[gi*4 +: 4]),
      .p  (p_w[gi*4 +: 4]),
      .ci (gc_w[gi]),
      .c  (c_w[gi*4 +: 4]),
      .gg (gg_w[gi]),
      .pg (pg_w[gi])
    );
  end

  assign sum_w = p_w[NBIT-1:0] ^ c_w[NBIT-1:0];

  // With a partial top group the zero-propagate padding blocks the group
  // carry-out, so take the carry into the first padding bit instead.
  if (NBIT % 4 == 0) begin : g_cout_full
    assign cout_w = gc_w[NGRP];
  end else begin : g_cout_part
    assign cout_w = c_w[NBIT];
  end

  logic unused_w;
  assign unused_w = ^{gc_w, c_w, gg_w, pg_w};

  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    vld_d  = in_valid;
    if (in_valid) begin
      s_d    = sum_w;
      cout_d = cout_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;
endmodule

// File: tb/tb_cla_adder_reg.sv
// Directed-vector and sweep bench for cla_adder_reg at NBIT=4 and NBIT=10.

module tb_cla_adder_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cin, in_valid;
  logic [3:0]  a4, b4, s4;
  logic        cout4, ov4;
  logic [9:0]  a10, b10, s10;
  logic        cout10, ov10;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_adder_reg #(.NBIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin), .in_valid(in_valid),
    .s(s4), .cout(cout4), .out_valid(ov4)
  );

  cla_adder_reg #(.NBIT(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .a(a10), .b(b10), .cin(cin), .in_valid(in_valid),
    .s(s10), .cout(cout10), .out_valid(ov10)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] es;
    logic       ec;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic c, input logic v);
    @(negedge clk);
    a4 = av; b4 = bv; cin = c; in_valid = v;
    a10 = {6'b0, av}; b10 = {6'b0, bv};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] exp10;
    logic [4:0]  exp4;

    vt[0] = '{4'd1,  4'd2,  1'b0, 4'd3,  1'b0};
    vt[1] = '{4'd5,  4'd2,  1'b0, 4'd7,  1'b0};
    vt[2] = '{4'd5,  4'd11, 1'b0, 4'd0,  1'b1};
    vt[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    vt[4] = '{4'd15, 4'd0,  1'b1, 4'd0,  1'b1};
    vt[5] = '{4'd3,  4'd4,  1'b0, 4'd7,  1'b0};
    vt[6] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
    vt[7] = '{4'd7,  4'd8,  1'b1, 4'd0,  1'b1};

    // Reset held with live operands and clocks running
    rst_n = 1'b0; a4 = 4'd5; b4 = 4'd3; cin = 1'b0; in_valid = 1'b1;
    a10 = 10'd5; b10 = 10'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_s", s4, 0);
      chk("rst_cout", cout4, 0);
      chk("rst_ov", ov4, 0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    step();
    chk("post_rst_s", s4, 0);
    chk("post_rst_cout", cout4, 0);
    chk("post_rst_ov", ov4, 1);

    // Back-to-back table, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].a, vt[i].b, vt[i].cin, 1'b1);
      step();
      chk($sformatf("vec%0d_s", i), s4, vt[i].es);
      chk($sformatf("vec%0d_cout", i), cout4, vt[i].ec);
      chk($sformatf("vec%0d_ov", i), ov4, 1);
    end

    // Mid-cycle input change must not reach the registers
    a4 = 4'd15; b4 = 4'd1;
    #2;
    chk("glitch_s", s4, 0);
    chk("glitch_cout", cout4, 1);

    drive(4'd9, 4'd9, 1'b0, 1'b0);
    step();
    chk("hold_s", s4, 0);
    chk("hold_cout", cout4, 1);
    chk("hold_ov", ov4, 0);

    // Asynchronous reset between edges
    drive(4'd1, 4'd2, 1'b0, 1'b1);
    step();
    chk("pre_arst_s", s4, 3);
    chk("pre_arst_ov", ov4, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_s", s4, 0);
    chk("arst_cout", cout4, 0);
    chk("arst_ov", ov4, 0);
    step();
    drive(4'd6, 4'd9, 1'b1, 1'b1);
    rst_n = 1'b1;
    step();
    chk("rel_s", s4, 0);
    chk("rel_cout", cout4, 1);
    chk("rel_ov", ov4, 1);

    // NBIT=10 all-ones corners
    @(negedge clk);
    a10 = 10'h3FF; b10 = 10'h3FF; cin = 1'b1; in_valid = 1'b1;
    step();
    chk("w10_ones_s", s10, 10'h3FF);
    chk("w10_ones_cout", cout10, 1);
    @(negedge clk);
    a10 = 10'h3FF; b10 = 10'h000; cin = 1'b1;
    step();
    chk("w10_wrap_s", s10, 0);
    chk("w10_wrap_cout", cout10, 1);

    // Exhaustive NBIT=4, random NBIT=10
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4 = i[3:0]; b4 = i[7:4]; cin = i[8]; in_valid = 1'b1;
      a10 = 10'($urandom_range(0, 1023));
      b10 = 10'($urandom_range(0, 1023));
      exp4  = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
      exp10 = 11'(a10) + 11'(b10) + 11'(i[8]);
      step();
      chk($sformatf("sweep4_%0d", i), {cout4, s4}, exp4);
      chk($sformatf("sweep10_%0d", i), {cout10, s10}, exp10);
    end
    chk("sweep_ov", ov10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cla_adder_reg.md
Name:
cla_adder_reg

Overview:
- NBIT-wide carry-lookahead adder computing a + b + cin.
- Built from 4-bit lookahead groups with a second-level group carry-lookahead unit.
- Sum and carry-out are registered, giving one cycle of latency.
- Used as a general arithmetic building block in the datapath and as the reference adder for adder-architecture comparisons.

Parameters:
- NBIT, 4, operand and sum width; any integer >= 1; the last lookahead group may be partial when NBIT is not a multiple of 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  NBIT  operand A, unsigned
- b  input  NBIT  operand B, unsigned
- cin  input  1  carry-in
- in_valid  input  1  operands valid this cycle
- s  output  NBIT  registered sum, (a+b+cin) mod 2^NBIT
- cout  output  1  registered carry-out, bit NBIT of a+b+cin
- out_valid  output  1  s/cout hold a result captured from a valid input

Behaviour:
- Reset:
  - rst_n low clears s, cout and out_valid to 0 immediately, independent of clk.
  - Deassertion takes effect at the next rising edge.
- Bit level:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
  - s[i] = p[i] ^ c[i], with c[0] = cin.
- Group level (4 bits each):
  - Carries inside a group come from flattened lookahead equations, not a ripple chain.
  - Example: c1 = g0 | p0&c0; c2 = g1 | p1&g0 | p1&p0&c0; and so on.
  - Each group produces a group generate G and group propagate P.
- Second level:
  - Group carry-ins come from the lookahead of G/P, e.g. C1 = G0 | P0&cin.
  - cout is the carry out of the top group.
- Timing:
  - Each rising edge with in_valid=1 captures the combinational result into s and cout; out_valid is set to 1.
  - With in_valid=0, s and cout hold their previous values and out_valid drops to 0.
  - Latency is exactly 1 cycle; a new operand set is accepted every cycle.
- Arithmetic:
  - Unsigned only; there is no overflow flag.
  - Full wrap-around: all-ones + all-ones + 1 gives s = all-ones, cout = 1.
  - All-ones + 0 + 1 gives s = 0, cout = 1.
- Inputs are sampled only at the clock edge; glitches between edges have no effect.
- Reset asserted mid-stream discards the in-flight result. The first valid input after release produces out_valid one cycle later.
- Partial top group (NBIT mod 4 != 0): unused group bits are tied to g=0, p=0, and cout is the carry out of bit NBIT-1.

Test Plan:
- Reset: hold rst_n=0 with a=5, b=3, clocks running -> s=0, cout=0, out_valid=0 throughout. Release; in_valid=1 with a=0, b=0, cin=0 -> next cycle s=0, cout=0, out_valid=1.
- a=1, b=2, cin=0, in_valid=1 -> next edge s=3, cout=0. Then a=5, b=2 -> s=7, cout=0.
- a=5, b=11, cin=0 -> s=0, cout=1, exercising full carry propagation through all bits.
- a=15, b=15, cin=1 -> s=15, cout=1. Also a=15, b=0, cin=1 -> s=0, cout=1.
- Back-to-back: in_valid=1 for three cycles with (3,4,0), (8,8,0), (7,8,1) -> outputs 7/0, 0/1, 0/1 on consecutive cycles. Then in_valid=0 -> s/cout hold 0/1, out_valid=0.
- Asynchronous reset mid-stream: pulse rst_n low between edges while out_valid=1 -> s, cout and out_valid clear immediately without waiting for clk. Randomized sweep with NBIT=4 (exhaustive) and NBIT=10 (partial group) matches the golden {cout,s} = a+b+cin.
